// File: rtl/sobel_pkg.sv
// Shared types and constants for the sobel frame controller and its helpers.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Widest supported threshold; callers slice the low DATA_WIDTH bits.
    localparam logic [31:0] DEF_THRESHOLD = 32'hFFFF_FFFF;

    // Bits needed to hold a count from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // True when a counter of width w can represent max_val without wrapping.
    function automatic bit cnt_fits(input int max_val, input int w);
        return (max_val < (1 << w));
    endfunction

endpackage

// File: rtl/sobel_edge_det.sv
// Registered single-polarity edge detector: remembers the previous sample and
// flags a rising (DETECT_RISE=1) or falling (DETECT_RISE=0) transition.
module sobel_edge_det #(
    parameter bit DETECT_RISE = 1'b1
) (
    input  logic clk,
    input  logic reset_p,
    input  logic sig,
    output logic pulse
);

    logic prev;

    // Previous-sample register
    always_ff @(posedge clk) begin
        if (reset_p) begin
            prev <= 1'b0;
        end else begin
            prev <= sig;
        end
    end

    assign pulse = DETECT_RISE ? (sig & ~prev) : (~sig & prev);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller around the sobel datapath: threshold shadowing, geometry
// check and border masking (border mask enabled by SOBEL_CTRL_BORDER_MASK_EN).
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 12,
    parameter int ROW_W      = 11
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [DATA_WIDTH-1:0] cfg_threshold,
    input  logic                  cfg_update,
    input  logic                  in_vs,
    output logic [DATA_WIDTH-1:0] sobel_threshold,
    input  logic                  sobel_out,
    input  logic                  sobel_out_valid,
    input  logic                  sobel_out_hs,
    input  logic                  sobel_out_vs,
    output logic                  edge_out,
    output logic                  edge_valid,
    output logic                  edge_hs,
    output logic                  edge_vs,
    output logic                  frame_done,
    output logic                  size_err,
    output logic                  busy
);

    localparam logic [COL_W-1:0] COL_MAX = {COL_W{1'b1}};
    localparam logic [ROW_W-1:0] ROW_MAX = {ROW_W{1'b1}};

    state_t                  state;
    state_t                  next_state;
    logic                    in_vs_rise;
    logic                    hs_fall;
    logic                    vs_fall;
    logic                    pend_flag;
    logic [DATA_WIDTH-1:0]   pend_val;
    logic [COL_W-1:0]        col_cnt;
    logic [ROW_W-1:0]        row_cnt;
    logic                    line_err;
    logic                    frame_start;
    logic                    pix;

    sobel_edge_det #(.DETECT_RISE(1'b1)) u_in_vs_det (
        .clk(clk), .reset_p(reset_p), .sig(in_vs), .pulse(in_vs_rise)
    );
    sobel_edge_det #(.DETECT_RISE(1'b0)) u_hs_det (
        .clk(clk), .reset_p(reset_p), .sig(sobel_out_hs), .pulse(hs_fall)
    );
    sobel_edge_det #(.DETECT_RISE(1'b0)) u_vs_det (
        .clk(clk), .reset_p(reset_p), .sig(sobel_out_vs), .pulse(vs_fall)
    );

    assign frame_start = (state == ST_WAIT) && in_vs_rise;
    assign pix         = sobel_out_valid & sobel_out_hs & sobel_out_vs;

`ifdef SOBEL_CTRL_BORDER_MASK_EN
    logic border;
    // Window positions still holding padding or the previous line are blanked
    assign border = (state == ST_ACTIVE) &&
                    ((row_cnt < ROW_W'(2)) || (col_cnt < COL_W'(2)));
`endif

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!in_vs) next_state = ST_WAIT;
                else        next_state = ST_IDLE;
            end
            ST_WAIT: begin
                if (in_vs_rise) next_state = ST_ACTIVE;
                else            next_state = ST_WAIT;
            end
            ST_ACTIVE: begin
                if (vs_fall) next_state = ST_DONE;
                else         next_state = ST_ACTIVE;
            end
            ST_DONE:  next_state = ST_WAIT;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State, threshold shadow, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state           <= ST_IDLE;
            sobel_threshold <= DEF_THRESHOLD[DATA_WIDTH-1:0];
            pend_flag       <= 1'b0;
            pend_val        <= {DATA_WIDTH{1'b0}};
            col_cnt         <= {COL_W{1'b0}};
            row_cnt         <= {ROW_W{1'b0}};
            line_err        <= 1'b0;
            size_err        <= 1'b0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
            edge_out        <= 1'b0;
            edge_valid      <= 1'b0;
            edge_hs         <= 1'b0;
            edge_vs         <= 1'b0;
        end else begin
            state      <= next_state;
            busy       <= (next_state == ST_ACTIVE);
            frame_done <= (next_state == ST_DONE);

            // A same-cycle request beats the pending one at frame start
            if (frame_start) begin
                if (cfg_update)     sobel_threshold <= cfg_threshold;
                else if (pend_flag) sobel_threshold <= pend_val;
                pend_flag <= 1'b0;
            end else if (cfg_update) begin
                pend_flag <= 1'b1;
                pend_val  <= cfg_threshold;
            end

            if (frame_start) begin
                col_cnt  <= {COL_W{1'b0}};
                row_cnt  <= {ROW_W{1'b0}};
                line_err <= 1'b0;
            end else if (state == ST_ACTIVE) begin
                if (hs_fall) begin
                    if (col_cnt != COL_W'(IMG_WIDTH)) line_err <= 1'b1;
                    if (row_cnt != ROW_MAX)           row_cnt  <= row_cnt + ROW_W'(1);
                    col_cnt <= {COL_W{1'b0}};
                end else if (pix && (col_cnt != COL_MAX)) begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end

            if (state == ST_DONE) begin
                size_err <= line_err | (row_cnt != ROW_W'(IMG_HEIGHT));
            end

            edge_valid <= sobel_out_valid;
            edge_hs    <= sobel_out_hs;
            edge_vs    <= sobel_out_vs;
`ifdef SOBEL_CTRL_BORDER_MASK_EN
            edge_out   <= sobel_out & ~border;
`else
            edge_out   <= sobel_out;
`endif
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Randomized bench for sobel_frame_ctrl with a frame-level reference model.
module tb_sobel_frame_ctrl;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
`ifdef SOBEL_CTRL_BORDER_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_p = 1'b1;
    logic [DW-1:0] cfg_threshold = 8'd0;
    logic          cfg_update = 1'b0;
    logic          in_vs = 1'b0;
    logic [DW-1:0] sobel_threshold;
    logic          sobel_out = 1'b0;
    logic          sobel_out_valid = 1'b0;
    logic          sobel_out_hs = 1'b0;
    logic          sobel_out_vs = 1'b0;
    logic          edge_out, edge_valid, edge_hs, edge_vs;
    logic          frame_done, size_err, busy;

    sobel_frame_ctrl #(
        .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(12), .ROW_W(11)
    ) dut (
        .clk(clk), .reset_p(reset_p),
        .cfg_threshold(cfg_threshold), .cfg_update(cfg_update),
        .in_vs(in_vs), .sobel_threshold(sobel_threshold),
        .sobel_out(sobel_out), .sobel_out_valid(sobel_out_valid),
        .sobel_out_hs(sobel_out_hs), .sobel_out_vs(sobel_out_vs),
        .edge_out(edge_out), .edge_valid(edge_valid),
        .edge_hs(edge_hs), .edge_vs(edge_vs),
        .frame_done(frame_done), .size_err(size_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ones   = 0;
    int dones  = 0;

    // Reference model state (frame-level view of the controller)
    logic [DW-1:0] m_thr, m_pval;
    bit m_pend, m_trk, m_armed, m_idle, m_err, m_size, m_size_next, m_size_pend;
    int m_line, m_pix;
    bit p_ivs, p_hs, p_vs;

    // Expected outputs after the coming clock edge, and their staged copies
    logic          e_eo, e_v, e_hs, e_vs, e_done, e_size, e_busy;
    logic [DW-1:0] e_thr;
    logic          q_eo, q_v, q_hs, q_vs, q_done, q_size, q_busy;
    logic [DW-1:0] q_thr;
    bit            staged = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus plus the model's view of what it must produce
    task automatic step(input logic v, input logic hs, input logic vs, input logic so,
                        input logic ivs, input logic cu, input logic [DW-1:0] cv,
                        input logic rst);
        bit start;
        sobel_out_valid = v; sobel_out_hs = hs; sobel_out_vs = vs; sobel_out = so;
        in_vs = ivs; cfg_update = cu; cfg_threshold = cv; reset_p = rst;
        if (rst) begin
            m_thr = 8'hFF; m_pval = 8'h00; m_pend = 1'b0; m_trk = 1'b0;
            m_armed = 1'b0; m_idle = 1'b1; m_err = 1'b0; m_size = 1'b0;
            m_size_pend = 1'b0; m_line = 0; m_pix = 0;
            p_ivs = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
            e_eo = 1'b0; e_v = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
            e_done = 1'b0; e_size = 1'b0; e_busy = 1'b0; e_thr = 8'hFF;
        end else begin
            start = m_armed && !m_trk && ivs && !p_ivs;
            e_v = v; e_hs = hs; e_vs = vs;
            e_eo = so & ~(MASK_EN && m_trk && (m_line < 2 || m_pix < 2));
            e_done = 1'b0;
            if (m_size_pend) begin
                m_size = m_size_next; m_size_pend = 1'b0; m_armed = 1'b1;
            end
            if (start) begin
                if (cu) m_thr = cv;
                else if (m_pend) m_thr = m_pval;
                m_pend = 1'b0;
            end else if (cu) begin
                m_pend = 1'b1; m_pval = cv;
            end
            if (m_trk) begin
                if (p_hs && !hs) begin
                    if (m_pix != W) m_err = 1'b1;
                    m_line++; m_pix = 0;
                end else if (v && hs && vs) begin
                    m_pix++;
                end
                if (p_vs && !vs) begin
                    m_trk = 1'b0; e_done = 1'b1;
                    m_size_next = m_err || (m_line != H); m_size_pend = 1'b1;
                end
            end
            if (start) begin
                m_trk = 1'b1; m_armed = 1'b0; m_line = 0; m_pix = 0; m_err = 1'b0;
            end
            if (m_idle && !ivs) begin
                m_idle = 1'b0; m_armed = 1'b1;
            end
            e_busy = m_trk; e_thr = m_thr; e_size = m_size;
            p_ivs = ivs; p_hs = hs; p_vs = vs;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 8'd0, 0);
    endtask

    task automatic send_frame(input int nlines, input int short_line, input int empty_line,
                              input int rst_line, input bit all_ones, input bit upd_rise,
                              input logic [DW-1:0] rise_val, input int mid_line,
                              input logic [DW-1:0] mid_val, input bit simul, input int max_gap);
        bit iv;
        int np;
        int g;
        logic so;
        step(0, 0, 0, 0, 1, upd_rise, rise_val, 0);
        step(0, 0, 0, 0, 1, 0, 8'd0, 0);
        step(0, 0, 1, 0, 1, 0, 8'd0, 0);
        for (int l = 0; l < nlines; l++) begin
            iv = (l != nlines - 1);
            np = (l == short_line) ? W - 1 : ((l == empty_line) ? 0 : W);
            if (l == rst_line) begin
                step(0, 0, 1, 0, iv, 0, 8'd0, 1);
                step(0, 0, 1, 0, iv, 0, 8'd0, 1);
            end
            if (np == 0) begin
                step(0, 1, 1, 0, iv, (l == mid_line), mid_val, 0);
                step(0, 1, 1, 0, iv, 0, 8'd0, 0);
            end
            for (int p = 0; p < np; p++) begin
                g = $urandom_range(max_gap, 0);
                for (int k = 0; k < g; k++) step(0, 1, 1, 0, iv, 0, 8'd0, 0);
                so = all_ones ? 1'b1 : 1'($urandom);
                step(1, 1, 1, so, iv, (l == mid_line && p == 0), mid_val, 0);
            end
            if (simul && l == nlines - 1) begin
                step(0, 0, 0, 0, 0, 0, 8'd0, 0);
            end else begin
                step(0, 0, 1, 0, iv, 0, 8'd0, 0);
                step(0, 0, 1, 0, iv, 0, 8'd0, 0);
            end
        end
        idle(4);
    endtask

    // Stage the model's expectations at the edge that consumes the inputs
    always @(posedge clk) begin
        q_eo <= e_eo; q_v <= e_v; q_hs <= e_hs; q_vs <= e_vs;
        q_done <= e_done; q_size <= e_size; q_busy <= e_busy; q_thr <= e_thr;
        staged <= 1'b1;
    end

    // Compare every DUT output against the model away from the active edge
    always @(negedge clk) begin
        if (staged) begin
            check("edge_out",   32'(edge_out),   32'(q_eo));
            check("edge_valid", 32'(edge_valid), 32'(q_v));
            check("edge_hs",    32'(edge_hs),    32'(q_hs));
            check("edge_vs",    32'(edge_vs),    32'(q_vs));
            check("frame_done", 32'(frame_done), 32'(q_done));
            check("size_err",   32'(size_err),   32'(q_size));
            check("busy",       32'(busy),       32'(q_busy));
            check("threshold",  32'(sobel_threshold), 32'(q_thr));
            if (edge_valid && edge_out) ones++;
            if (frame_done) dones++;
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 8'd0, 1);
        step(0, 0, 0, 0, 0, 0, 8'd0, 1);
        idle(3);
        check("lit_reset_thr", 32'(sobel_threshold), 32'hFF);
        check("lit_reset_size", 32'(size_err), 32'h0);

        step(0, 0, 0, 0, 0, 1, 8'd40, 0);
        idle(2);
        ones = 0;
        send_frame(H, -1, -1, -1, 1, 0, 8'd0, -1, 8'd0, 0, 2);
        check("lit_ones", 32'(ones), MASK_EN ? 32'd24 : 32'd48);
        check("lit_thr40", 32'(sobel_threshold), 32'd40);
        check("lit_size_clean", 32'(size_err), 32'h0);

        send_frame(H, -1, -1, -1, 0, 0, 8'd0, 2, 8'd60, 0, 3);
        check("lit_thr_hold40", 32'(sobel_threshold), 32'd40);
        send_frame(H, -1, -1, -1, 0, 0, 8'd0, -1, 8'd0, 0, 1);
        check("lit_thr60", 32'(sobel_threshold), 32'd60);
        send_frame(H, -1, -1, -1, 0, 1, 8'd70, -1, 8'd0, 1, 1);
        check("lit_thr70", 32'(sobel_threshold), 32'd70);

        send_frame(H, 2, -1, -1, 0, 0, 8'd0, -1, 8'd0, 0, 1);
        check("lit_short_line", 32'(size_err), 32'h1);
        send_frame(H, -1, -1, -1, 0, 0, 8'd0, -1, 8'd0, 0, 1);
        check("lit_recover", 32'(size_err), 32'h0);
        send_frame(H - 1, -1, -1, -1, 0, 0, 8'd0, -1, 8'd0, 0, 1);
        check("lit_five_lines", 32'(size_err), 32'h1);

        dones = 0;
        send_frame(H, -1, -1, 3, 0, 0, 8'd0, -1, 8'd0, 0, 1);
        check("lit_rst_no_done", 32'(dones), 32'd0);
        check("lit_rst_thr", 32'(sobel_threshold), 32'hFF);
        send_frame(H, -1, -1, -1, 0, 0, 8'd0, -1, 8'd0, 1, 3);
        check("lit_after_rst_done", 32'(dones), 32'd1);
        check("lit_after_rst_size", 32'(size_err), 32'h0);

        send_frame(H, -1, 1, -1, 0, 0, 8'd0, -1, 8'd0, 0, 1);
        check("lit_empty_line", 32'(size_err), 32'h1);

        for (int f = 0; f < 10; f++) begin
            send_frame($urandom_range(H + 1, H - 1),
                       ($urandom_range(3, 0) == 0) ? int'($urandom_range(H - 2, 0)) : -1,
                       -1, -1, 1'($urandom), 1'($urandom), 8'($urandom),
                       int'($urandom_range(H, 0)), 8'($urandom),
                       1'($urandom), 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
